micro_alpha_veryl_iterative_shifter: RTL and testbench

- Multi-cycle shift unit for the MICRO-1 datapath. It accepts a shift request with a shift amount of 0-15 and applies single-bit shifts, one per clock, using the same per-step semantics as the combinational shifter (`shifter_operation_t` from `micro_alpha_veryl_shifter_pkg`).
- Non-shift operations complete in one cycle.
- It sits between the sequencer, which issues requests, and the register-file write-back, which consumes results, using a valid/ready handshake on both sides.

---
 rtl/micro_alpha_veryl_iterative_shifter.sv | 161 ++++++++++++++++
 tb/tb_micro_alpha_veryl_iterative_shifter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/micro_alpha_veryl_iterative_shifter.sv
// MICRO-1 iterative shifter: applies one single-bit shift step per clock.
// Non-shift operations complete at the accept edge; results leave over a valid/ready port.
package micro_alpha_veryl_shifter_pkg;
  localparam int MICRO1_MACHINE_WORD = 16;

  typedef enum logic [2:0] {
    NOP                  = 3'd0,
    LEFT_LOGICALLY       = 3'd1,
    RIGHT_LOGICALLY      = 3'd2,
    LEFT_ARITHMETICALLY  = 3'd3,
    RIGHT_ARITHMETICALLY = 3'd4,
    EXTENSION            = 3'd5,
    SWAP                 = 3'd6
  } shifter_operation_t;
endpackage

module micro_alpha_veryl_iterative_shifter
  import micro_alpha_veryl_shifter_pkg::*;
#(
  parameter int AMOUNT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  shifter_operation_t             operation,
  input  logic [AMOUNT_WIDTH-1:0]        amount,
  input  logic [MICRO1_MACHINE_WORD-1:0] in,
  input  logic                           cin,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [MICRO1_MACHINE_WORD-1:0] out,
  output logic                           cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                         state;
  state_t                         state_next;
  shifter_operation_t             op_q;
  logic                           cin_q;
  logic [AMOUNT_WIDTH-1:0]        count;
  logic                           accept;
  logic                           is_shift;
  logic [MICRO1_MACHINE_WORD-1:0] load_w;
  logic                           load_c;
  logic [MICRO1_MACHINE_WORD-1:0] step_w;
  logic                           step_c;

  // req_ready also gated by rst so nothing is offered while reset is held.
  assign req_ready = rst && (state == IDLE);
  assign res_valid = (state == DONE);
  assign accept    = req_valid && req_ready;

  // Value loaded at the accept edge; for shifts it doubles as the amount==0 result.
  always_comb begin
    is_shift = 1'b0;
    load_w   = in;
    load_c   = 1'b0;
    case (operation)
      LEFT_LOGICALLY, RIGHT_LOGICALLY, LEFT_ARITHMETICALLY, RIGHT_ARITHMETICALLY: begin
        is_shift = 1'b1;
        load_c   = cin;
      end
      EXTENSION: begin
        load_w = {{8{in[7]}}, in[7:0]};
        load_c = in[7];
      end
      SWAP: load_w = {in[7:0], in[15:8]};
      default: ;
    endcase
  end

  // One shift step on the work register (out); the latched cin is the fill every step.
  always_comb begin
    step_w = out;
    step_c = cout;
    case (op_q)
      LEFT_LOGICALLY: begin
        step_w = {out[14:0], cin_q};
        step_c = out[15];
      end
      RIGHT_LOGICALLY: begin
        step_w = {cin_q, out[15:1]};
        step_c = out[0];
      end
      LEFT_ARITHMETICALLY: begin
        step_w = {out[15], out[13:0], cin_q};
        step_c = out[14];
      end
      RIGHT_ARITHMETICALLY: begin
        step_w = {out[15], out[15:1]};
        step_c = out[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (is_shift && (amount != '0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (count == AMOUNT_WIDTH'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= '0;
      cout  <= 1'b0;
      count <= '0;
      op_q  <= NOP;
      cin_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= operation;
            cin_q <= cin;
            count <= amount;
            out   <= load_w;
            cout  <= load_c;
          end
        end
        SHIFT: begin
          out   <= step_w;
          cout  <= step_c;
          count <= count - AMOUNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_alpha_veryl_iterative_shifter.sv
// Randomized scoreboard bench for the iterative shifter: driver pushes expectations,
// monitor pops and compares whenever a result is presented.
module tb_micro_alpha_veryl_iterative_shifter;
  import micro_alpha_veryl_shifter_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  shifter_operation_t operation;
  logic [3:0]         amount;
  logic [15:0]        in;
  logic               cin;
  logic               res_valid;
  logic               res_ready;
  logic [15:0]        out;
  logic               cout;

  micro_alpha_veryl_iterative_shifter #(.AMOUNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .operation(operation), .amount(amount), .in(in), .cin(cin),
    .res_valid(res_valid), .res_ready(res_ready), .out(out), .cout(cout)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [15:0] out;
    logic        cout;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        force_stall = 1'b0;
  logic        have_cur = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_shift_op(input shifter_operation_t op);
    return op inside {LEFT_LOGICALLY, RIGHT_LOGICALLY, LEFT_ARITHMETICALLY, RIGHT_ARITHMETICALLY};
  endfunction

  // Shifting by n equals shifting the word concatenated with n fill bits; the
  // carry is the last original bit pushed across the edge.
  function automatic logic [16:0] model(input shifter_operation_t op, input int n,
                                        input logic [15:0] w, input logic c);
    logic [31:0] x;
    logic [29:0] y;
    if (is_shift_op(op) && n == 0) return {w, c};
    case (op)
      LEFT_LOGICALLY: begin
        x = {w, {16{c}}} << n;
        return {x[31:16], w[16-n]};
      end
      RIGHT_LOGICALLY: begin
        x = {{16{c}}, w} >> n;
        return {x[15:0], w[n-1]};
      end
      LEFT_ARITHMETICALLY: begin
        y = {w[14:0], {15{c}}} << n;
        return {w[15], y[29:15], w[15-n]};
      end
      RIGHT_ARITHMETICALLY: begin
        x = {{16{w[15]}}, w} >> n;
        return {x[15:0], w[n-1]};
      end
      EXTENSION: return {{8{w[7]}}, w[7:0], w[7]};
      SWAP:      return {w[7:0], w[15:8], 1'b0};
      default:   return {w, 1'b0};
    endcase
  endfunction

  // Clock edges between the accept edge and the edge that raises res_valid:
  // n step edges for a shift with n>0; immediate DONE otherwise.
  function automatic int model_lat(input shifter_operation_t op, input int n);
    return (is_shift_op(op) && n > 0) ? n : 0;
  endfunction

  task automatic send(input shifter_operation_t op, input int n,
                      input logic [15:0] w, input logic c);
    logic [16:0] r;
    bit          done = 0;
    @(negedge clk);
    operation = op; amount = 4'(n); in = w; cin = c; req_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (req_ready) begin
        r = model(op, n, w, c);
        q.push_back('{out: r[16:1], cout: r[0], acc: cycle + 1, lat: model_lat(op, n)});
        done = 1;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || have_cur) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  // Monitor: compare on the first cycle of each result, then demand stability until the handshake.
  initial begin
    exp_t        e;
    logic [15:0] held_out;
    logic        held_cout;
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_cur = 1'b0;
      end else if (res_valid) begin
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        if (!have_cur) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 32'(out), 32'hDEAD_0000);
          end else begin
            e = q.pop_front();
            chk("latency", 32'(cycle - e.acc), 32'(e.lat));
            chk("out", 32'(out), 32'(e.out));
            chk("cout", 32'(cout), 32'(e.cout));
            $display("result out=%h cout=%0b lat=%0d", out, cout, cycle - e.acc);
          end
          have_cur = 1'b1;
          held_out = out;
          held_cout = cout;
        end else begin
          chk("hold_out", 32'(out), 32'(held_out));
          chk("hold_cout", 32'(cout), 32'(held_cout));
        end
      end
      res_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (res_valid && res_ready && rst) have_cur = 1'b0;
    end
  end

  initial begin
    logic [2:0] rop;
    int         k;
    rst = 1'b0; req_valid = 1'b0; operation = NOP; amount = '0; in = '0; cin = 1'b0;
    #2;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk("idle_req_ready", 32'(req_ready), 32'd1);

    send(LEFT_LOGICALLY, 1, 16'hA5A5, 1'b0);
    send(RIGHT_LOGICALLY, 4, 16'hA5A5, 1'b1);
    send(RIGHT_ARITHMETICALLY, 15, 16'h8000, 1'b0);
    send(LEFT_LOGICALLY, 0, 16'h1234, 1'b1);
    send(SWAP, 7, 16'h0123, 1'b0);
    send(EXTENSION, 0, 16'h00FF, 1'b0);
    send(EXTENSION, 0, 16'h007F, 1'b1);
    send(LEFT_ARITHMETICALLY, 3, 16'hC001, 1'b1);
    send(LEFT_ARITHMETICALLY, 15, 16'h7FFF, 1'b0);
    send(LEFT_LOGICALLY, 15, 16'h0001, 1'b1);
    send(shifter_operation_t'(3'd7), 9, 16'hBEEF, 1'b1);
    drain();

    // Backpressure: result held for 5 cycles while another request waits.
    force_stall = 1'b1;
    send(RIGHT_LOGICALLY, 2, 16'h0F0F, 1'b1);
    k = 0;
    while (!res_valid && k < 50) begin @(negedge clk); k++; end
    chk("bp_valid_seen", 32'(res_valid), 32'd1);
    operation = NOP; in = 16'h5555; amount = 4'd0; cin = 1'b0; req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    force_stall = 1'b0;
    send(NOP, 0, 16'h5555, 1'b0);
    drain();

    // Reset in the middle of a 10-step shift.
    send(RIGHT_LOGICALLY, 10, 16'hABCD, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("postrst_req_ready", 32'(req_ready), 32'd1);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      send(shifter_operation_t'(rop), int'($urandom_range(0, 15)),
           16'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
